// File: rtl/memory_cycle.sv
// Memory-access pipeline stage: byte/half/word loads and stores against a local data
// memory, the M/W pipeline register, and the combinational writeback mux.
module memory_cycle #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  ResultSrc_M,
    input  logic [2:0]  funct3_M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4_M,
    input  logic [31:0] WriteData_M,
    input  logic [31:0] ALU_Result_M,
    output logic        RegWrite_W,
    output logic [1:0]  ResultSrc_W,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4_W,
    output logic [31:0] ALU_Result_W,
    output logic [31:0] ReadData_W,
    output logic        MemFault_W,
    output logic [31:0] ResultW
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0]   mem_q [DMEM_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          is_load, is_store, load_illegal, store_illegal, misaligned, fault;
    logic [31:0]   rd_word, load_data, wr_data;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [3:0]    wr_be;

    logic          regwrite_q, regwrite_d, fault_q;
    logic [1:0]    resultsrc_q;
    logic [4:0]    rd_q;
    logic [31:0]   pcplus4_q, alu_q, rdata_q;

    assign idx           = ALU_Result_M[AW+1:2];
    assign off           = ALU_Result_M[1:0];
    assign is_load       = (ResultSrc_M == 2'b01);
    assign is_store      = MemWrite_M;
    assign load_illegal  = (funct3_M == 3'b011) || (funct3_M == 3'b110) || (funct3_M == 3'b111);
    assign store_illegal = funct3_M[2] || (funct3_M == 3'b011);
    assign misaligned    = ((funct3_M[1:0] == 2'b01) && off[0]) ||
                           ((funct3_M[1:0] == 2'b10) && (off != 2'b00));
    assign fault         = (is_load && (load_illegal || misaligned)) ||
                           (is_store && (store_illegal || misaligned));

    assign rd_word  = mem_q[idx];
    assign byte_sel = rd_word[{off, 3'b000} +: 8];
    assign half_sel = rd_word[{off[1], 4'b0000} +: 16];

    // Non-loads and faulting loads return 0 so unwritten (X) words never leak into W.
    always_comb begin
        load_data = '0;
        if (is_load && !fault) begin
            case (funct3_M)
                3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
                3'b010:  load_data = rd_word;
                3'b100:  load_data = {24'd0, byte_sel};
                3'b101:  load_data = {16'd0, half_sel};
                default: load_data = '0;
            endcase
        end
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = WriteData_M;
        case (funct3_M[1:0])
            2'b00:   wr_data = {4{WriteData_M[7:0]}};
            2'b01:   wr_data = {2{WriteData_M[15:0]}};
            default: wr_data = WriteData_M;
        endcase
        if (is_store && !fault) begin
            case (funct3_M[1:0])
                2'b00:   wr_be = 4'b0001 << off;
                2'b01:   wr_be = off[1] ? 4'b1100 : 4'b0011;
                2'b10:   wr_be = 4'b1111;
                default: wr_be = 4'b0000;
            endcase
        end
    end

    // Memory is not reset; rst only blocks writes while it is held low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign regwrite_d = RegWrite_M && !fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            rd_q        <= 5'd0;
            pcplus4_q   <= 32'd0;
            alu_q       <= 32'd0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= ResultSrc_M;
            rd_q        <= RD_M;
            pcplus4_q   <= PCPlus4_M;
            alu_q       <= ALU_Result_M;
            rdata_q     <= load_data;
            fault_q     <= fault;
        end
    end

    assign RegWrite_W   = regwrite_q;
    assign ResultSrc_W  = resultsrc_q;
    assign RD_W         = rd_q;
    assign PCPlus4_W    = pcplus4_q;
    assign ALU_Result_W = alu_q;
    assign ReadData_W   = rdata_q;
    assign MemFault_W   = fault_q;

    always_comb begin
        case (resultsrc_q)
            2'b00:   ResultW = alu_q;
            2'b01:   ResultW = rdata_q;
            2'b10:   ResultW = pcplus4_q;
            default: ResultW = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: a byte-addressed reference model predicts each
// instruction's W-stage outcome; a monitor compares one cycle after issue.
module tb_memory_cycle;
    localparam int W     = 1024;
    localparam int BYTES = 4 * W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWrite_M = 1'b0, MemWrite_M = 1'b0;
    logic [1:0]  ResultSrc_M = 2'b00;
    logic [2:0]  funct3_M = 3'b000;
    logic [4:0]  RD_M = 5'd0;
    logic [31:0] PCPlus4_M = 32'd0, WriteData_M = 32'd0, ALU_Result_M = 32'd0;
    logic        RegWrite_W, MemFault_W;
    logic [1:0]  ResultSrc_W;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4_W, ALU_Result_W, ReadData_W, ResultW;

    memory_cycle #(.DMEM_WORDS(W)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
        .funct3_M(funct3_M), .RD_M(RD_M), .PCPlus4_M(PCPlus4_M),
        .WriteData_M(WriteData_M), .ALU_Result_M(ALU_Result_M),
        .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W), .RD_W(RD_W),
        .PCPlus4_W(PCPlus4_W), .ALU_Result_W(ALU_Result_W), .ReadData_W(ReadData_W),
        .MemFault_W(MemFault_W), .ResultW(ResultW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] alu;
    } ins_t;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] resw;
        logic        fault;
        int          id;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mm [BYTES];
    int          n_vec = 0;
    int          n_err = 0;
    int          vid   = 0;
    logic        rst_next = 1'b1;

    logic        r_rw, r_mw;
    logic [1:0]  r_rs;
    logic [2:0]  r_f3;
    logic [31:0] r_alu;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h, expected %h", nm, id, got, exp);
        end
    endtask

    // Reference: memory is a flat byte array; an access of n bytes is legal only when
    // the address is a multiple of n and funct3 names a real access.
    function automatic exp_t model(input ins_t i, input logic live);
        exp_t        e;
        int          a, n;
        logic        ld, st, f;
        logic [31:0] v;
        e.rw = 1'b0; e.rs = 2'b00; e.rd = 5'd0; e.pc4 = '0; e.alu = '0;
        e.rdata = '0; e.resw = '0; e.fault = 1'b0; e.id = vid;
        if (!live) return e;
        a  = int'(i.alu % 32'(BYTES));
        n  = (i.f3[1:0] == 2'd0) ? 1 : (i.f3[1:0] == 2'd1) ? 2 : 4;
        ld = (i.rs == 2'b01);
        st = i.mw;
        f  = (ld && (i.f3 == 3'd3 || i.f3 >= 3'd6 || (a % n) != 0)) ||
             (st && (i.f3 >= 3'd3 || (a % n) != 0));
        v = '0;
        if (ld && !f) begin
            for (int k = 0; k < n; k++) v = v | (32'(mm[a+k]) << (8*k));
            if (!i.f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        end
        if (st && !f) begin
            for (int k = 0; k < n; k++) mm[a+k] = i.wd[8*k +: 8];
        end
        e.rw = i.rw && !f; e.rs = i.rs; e.rd = i.rd; e.pc4 = i.pc4; e.alu = i.alu;
        e.rdata = v; e.fault = f;
        case (i.rs)
            2'b00:   e.resw = i.alu;
            2'b01:   e.resw = v;
            2'b10:   e.resw = i.pc4;
            default: e.resw = '0;
        endcase
        return e;
    endfunction

    task automatic issue(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] pc4, input logic [31:0] wd,
                         input logic [31:0] alu);
        ins_t i;
        @(negedge clk);
        rst = rst_next;
        RegWrite_M = rw; MemWrite_M = mw; ResultSrc_M = rs; funct3_M = f3;
        RD_M = rd; PCPlus4_M = pc4; WriteData_M = wd; ALU_Result_M = alu;
        i.rw = rw; i.mw = mw; i.rs = rs; i.f3 = f3; i.rd = rd; i.pc4 = pc4; i.wd = wd; i.alu = alu;
        vid++;
        q.push_back(model(i, rst_next));
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] a);
        issue(1'b0, 1'b1, 2'b00, f3, 5'd0, 32'h0, wd, a);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a);
        issue(1'b1, 1'b0, 2'b01, f3, rd, 32'h0, 32'h0, a);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("RegWrite_W",   e.id, 32'(RegWrite_W),  32'(e.rw));
                chk("ResultSrc_W",  e.id, 32'(ResultSrc_W), 32'(e.rs));
                chk("RD_W",         e.id, 32'(RD_W),        32'(e.rd));
                chk("PCPlus4_W",    e.id, PCPlus4_W,        e.pc4);
                chk("ALU_Result_W", e.id, ALU_Result_W,     e.alu);
                chk("ReadData_W",   e.id, ReadData_W,       e.rdata);
                chk("MemFault_W",   e.id, 32'(MemFault_W),  32'(e.fault));
                chk("ResultW",      e.id, ResultW,          e.resw);
            end
        end
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        chk("reset RegWrite_W", 0, 32'(RegWrite_W), 32'd0);
        chk("reset RD_W",       0, 32'(RD_W),       32'd0);
        chk("reset ReadData_W", 0, ReadData_W,      32'd0);
        chk("reset MemFault_W", 0, 32'(MemFault_W), 32'd0);
        chk("reset ResultW",    0, ResultW,         32'd0);

        for (int w = 0; w < 16; w++) st(3'b010, $urandom, 32'(4*w));

        st(3'b010, 32'hDEADBEEF, 32'h10);
        ld(3'b010, 5'd5, 32'h10);

        st(3'b010, 32'h11223344, 32'h20);
        st(3'b000, 32'h00000080, 32'h21);
        ld(3'b010, 5'd1, 32'h20);
        ld(3'b000, 5'd2, 32'h21);
        ld(3'b100, 5'd3, 32'h21);
        st(3'b001, 32'h00009ABC, 32'h22);
        ld(3'b001, 5'd4, 32'h22);
        ld(3'b101, 5'd6, 32'h22);

        st(3'b010, 32'h12345678, 32'h31);
        ld(3'b010, 5'd7, 32'h30);
        ld(3'b010, 5'd8, 32'h31);
        ld(3'b001, 5'd9, 32'h33);
        st(3'b100, 32'h0000FFFF, 32'h30);
        ld(3'b111, 5'd10, 32'h30);

        st(3'b010, 32'hCAFEF00D, 32'h1000);
        ld(3'b010, 5'd11, 32'h0);

        issue(1'b1, 1'b0, 2'b00, 3'b000, 5'd12, 32'h0,   32'h0, 32'h55);
        issue(1'b1, 1'b0, 2'b10, 3'b000, 5'd13, 32'h104, 32'h0, 32'h0);
        issue(1'b1, 1'b0, 2'b11, 3'b000, 5'd14, 32'h0,   32'h0, 32'h77);

        st(3'b010, 32'h0, 32'h10);
        rst_next = 1'b0;
        st(3'b010, 32'hDEADBEEF, 32'h10);
        issue(1'b1, 1'b0, 2'b10, 3'b000, 5'd15, 32'h44, 32'h0, 32'h0);
        rst_next = 1'b1;
        ld(3'b010, 5'd16, 32'h10);

        for (int k = 0; k < 400; k++) begin
            r_rs = 2'($urandom_range(0, 3));
            r_mw = (r_rs != 2'b01) && ($urandom_range(0, 2) == 0);
            r_f3 = 3'($urandom);
            r_rw = 1'($urandom);
            if (r_rs == 2'b01 || r_mw)
                r_alu = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            else
                r_alu = $urandom;
            issue(r_rw, r_mw, r_rs, r_f3, 5'($urandom), $urandom, $urandom, r_alu);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the execute stage. Consumes the execute/memory pipeline-register outputs, performs byte/halfword/word loads and stores against an internal data memory, and registers results into the memory/writeback pipeline register. Also produces the combinational writeback result `ResultW`, which feeds the register file and the execute-stage forwarding muxes.

## Interface
- `DMEM_WORDS`, 1024: data memory depth in 32-bit words; power of two, at least 4.
- `clk  input  1`: clock; all state updates on the rising edge.
- `rst  input  1`: reset, asynchronous, active-low.
- `RegWrite_M  input  1`: instruction in M writes the register file.
- `MemWrite_M  input  1`: instruction in M is a store.
- `ResultSrc_M  input  2`: 00 ALU, 01 load, 10 PC+4; 11 reserved.
- `funct3_M  input  3`: access size and sign for loads and stores.
- `RD_M  input  5`: destination register.
- `PCPlus4_M  input  32`: PC+4 of the instruction.
- `WriteData_M  input  32`: store data, already forwarded.
- `ALU_Result_M  input  32`: effective byte address, or ALU result.
- `RegWrite_W  output  1`: registered `RegWrite_M`, forced to 0 on a fault.
- `ResultSrc_W  output  2`: registered `ResultSrc_M`.
- `RD_W  output  5`: registered `RD_M`.
- `PCPlus4_W  output  32`: registered `PCPlus4_M`.
- `ALU_Result_W  output  32`: registered `ALU_Result_M`.
- `ReadData_W  output  32`: registered, extended load data.
- `MemFault_W  output  1`: registered fault flag for the instruction now in W.
- `ResultW  output  32`: combinational writeback value.

## Operation
- **Load/store decode.**
  - An instruction is a load when `ResultSrc_M` is 01.
  - It is a store when `MemWrite_M` is 1.
  - Neither means no memory access occurs.
- **Addressing.**
  - The word index is `ALU_Result_M[log2(DMEM_WORDS)+1:2]`.
  - Higher address bits are ignored, so addresses wrap modulo `4*DMEM_WORDS` bytes.
  - The byte offset is `ALU_Result_M[1:0]`.
- **Loads.** Data is read combinationally from the addressed word, selected by the offset:
  - `funct3` 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half.
  - 010 LW: the full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half.
- **Stores.** On the rising edge, byte lanes are written:
  - `funct3` 000 SB writes `WriteData_M[7:0]` into the lane given by the offset.
  - 001 SH writes `WriteData_M[15:0]` into lanes {1,0} or {3,2}.
  - 010 SW writes all 4 lanes.
  - Unwritten lanes keep their value.
- **Faults.**
  - Misaligned access: a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠00.
  - Illegal `funct3`: load with 011, 110 or 111; store with `funct3[2]`=1 or 011.
  - On a fault: no memory lanes are written, load data is 0, `MemFault_W`=1 next cycle, and `RegWrite_W`=0.
  - Non-memory instructions never fault.
- **Writeback mux (`ResultW`).** Selected by `ResultSrc_W`:
  - 00: `ALU_Result_W`.
  - 01: `ReadData_W`.
  - 10: `PCPlus4_W`.
  - 11: 0.
- **Memory reset.** Memory contents are not reset; reads of unwritten words are X.
- **No stall/flush.** There is no stall or flush input. Upstream bubbles arrive as `RegWrite_M`=0 and `MemWrite_M`=0.

## Timing
- **Reset values.** While `rst`=0, all W outputs are 0, `MemFault_W`=0 and `ResultW`=0.
- **Writes during reset.** Memory writes are gated off while `rst`=0, so a store presented during reset is discarded.
- **Reset release.** The first rising edge after `rst` goes high captures M normally.
- **Latency.** Every M-stage field appears on the W outputs exactly 1 cycle after being presented. `ResultW` follows the W registers combinationally, with no added latency.
- **Store latency.** The store commits at the end of the cycle it is presented in M.
- **Store-then-load.** A load to the same address in the following cycle returns the new data; no bypass is needed.
- **One access per cycle.** There is exactly one instruction in M per cycle, so read and write never contend in the same cycle.

## Test plan
- **Reset.** Assert `rst`=0 mid-run while a store `SW` 0xDEADBEEF @0x10 is presented → all W outputs 0; a subsequent `LW` @0x10 after writing 0 shows 0 (the store was suppressed).
- **Word round-trip.** `SW` 0xDEADBEEF @0x10, then `LW` @0x10 in the next cycle, `RD_M`=5 → `ReadData_W`=0xDEADBEEF, `ResultW`=0xDEADBEEF, `RD_W`=5, `RegWrite_W`=1 one cycle later.
- **Sub-word loads/stores.**
  - After `SW` 0x11223344 @0x20, `SB` 0x80 @0x21 → `LW` @0x20 gives 0x11228044.
  - `LB` @0x21 gives 0xFFFFFF80; `LBU` @0x21 gives 0x00000080.
  - `SH` 0x9ABC @0x22, then `LH` @0x22 gives 0xFFFF9ABC; `LHU` gives 0x00009ABC.
- **Misaligned access.**
  - `SW` 0x12345678 @0x31 → memory word 0x30 is unchanged.
  - `LW` @0x31 → `MemFault_W`=1, `RegWrite_W`=0, `ReadData_W`=0.
  - `LH` @0x33 → fault.
- **Address wrap.** With `DMEM_WORDS`=1024, `SW` 0xCAFEF00D @0x1000, then `LW` @0x0 → 0xCAFEF00D.
- **Writeback mux.** Present `ResultSrc_M`=00 with ALU 0x55, then 10 with `PCPlus4` 0x104, then 11 on consecutive cycles → `ResultW` shows 0x55, 0x104, 0 on the three following cycles.
